// File: rtl/rf_pkg.sv
// Shared definitions for the forwarding register file.
// Contents: default geometry (RF_DATA_W, RF_NREG), the derived default
// index width, index/data typedefs at the default geometry, and the
// index of the hardwired zero register.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_NREG   = 32;
    localparam int RF_AW     = $clog2(RF_NREG);

    typedef logic [RF_AW-1:0]     reg_idx_t;
    typedef logic [RF_DATA_W-1:0] data_t;

    // Architectural register that reads as zero and never holds state.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   we0_i/wa0_i/clr0_i        write port 0 enable/index/retire
//   we1_i/wa1_i/clr1_i        write port 1 enable/index/retire
//   iss_v_i/iss_rd_i          issue: mark destination pending
//   flush_i                   clear every pending bit
//   rd_idx_i                  NRD packed read indices
//   rd_busy_o                 per port: source still pending after this
//                             cycle's writeback
//   any_busy_o                OR of the registered pending bits
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREG = RF_NREG,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we0_i,
    input  logic [AW-1:0]     wa0_i,
    input  logic              clr0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     wa1_i,
    input  logic              clr1_i,
    input  logic              iss_v_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic              flush_i,
    input  logic [NRD*AW-1:0] rd_idx_i,
    output logic [NRD-1:0]    rd_busy_o,
    output logic              any_busy_o
);

    localparam logic [AW-1:0] IDX0 = AW'(REG_ZERO);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // A writeback that also retires its destination this cycle.
    function automatic logic clr_hit(input logic [AW-1:0] idx);
        return (we0_i && clr0_i && (wa0_i == idx)) ||
               (we1_i && clr1_i && (wa1_i == idx));
    endfunction

    // Priority per entry: flush > issue set > writeback clear > hold.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NREG; i++) begin
            if (flush_i) begin
                pend_d[i] = 1'b0;
            end else if (iss_v_i && (iss_rd_i == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (clr_hit(AW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A same-cycle retire un-busies the consumer: the bypass supplies the data.
    for (genvar p = 0; p < NRD; p++) begin : g_busy
        logic [AW-1:0] idx;
        assign idx          = rd_idx_i[p*AW +: AW];
        assign rd_busy_o[p] = (idx != IDX0) && pend_q[idx] && !clr_hit(idx);
    end

    assign any_busy_o = |pend_q;

endmodule

// File: rtl/regfile_fwd_sb.sv
// Integer register file with NRD combinational read ports, two write
// ports with write-to-read forwarding, and a pending scoreboard.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rd_idx / rd_data     packed read indices / read data (port p slices)
//   rd_busy              per read port: source still pending
//   we0/wa0/wd0/clr0     write port 0 (older)
//   we1/wa1/wd1/clr1     write port 1 (younger, wins on collision)
//   iss_v/iss_rd         issue marks destination pending
//   flush                clears all pending bits
//   any_busy             any register pending
module regfile_fwd_sb
    import rf_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int NREG   = RF_NREG,
    parameter  int NRD    = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NRD*AW-1:0]     rd_idx,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  clr0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  clr1,
    input  logic                  iss_v,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  flush,
    output logic                  any_busy
);

    localparam logic [AW-1:0] IDX0 = AW'(REG_ZERO);

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    // Port 1 is applied last so it wins a same-index collision.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (we0) rf_d[wa0] = wd0;
        if (we1) rf_d[wa1] = wd1;
        rf_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Read mux: zero register, then the younger write, then the older one.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]     idx;
        logic [DATA_W-1:0] data;
        assign idx = rd_idx[p*AW +: AW];
        always_comb begin
            if (idx == IDX0) begin
                data = '0;
            end else if (we1 && (wa1 == idx)) begin
                data = wd1;
            end else if (we0 && (wa0 == idx)) begin
                data = wd0;
            end else begin
                data = rf_q[idx];
            end
        end
        assign rd_data[p*DATA_W +: DATA_W] = data;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .clk        (clk),
        .rstn       (rstn),
        .we0_i      (we0),
        .wa0_i      (wa0),
        .clr0_i     (clr0),
        .we1_i      (we1),
        .wa1_i      (wa1),
        .clr1_i     (clr1),
        .iss_v_i    (iss_v),
        .iss_rd_i   (iss_rd),
        .flush_i    (flush),
        .rd_idx_i   (rd_idx),
        .rd_busy_o  (rd_busy),
        .any_busy_o (any_busy)
    );

endmodule

// File: tb/tb_regfile_fwd_sb.sv
module tb_regfile_fwd_sb;
    import rf_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic [2*AW-1:0] rd_idx;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          we0, clr0, we1, clr1, iss_v, flush, any_busy;
    reg_idx_t      wa0, wa1, iss_rd;
    data_t         wd0, wd1;

    int n_chk = 0;
    int n_bad = 0;

    regfile_fwd_sb #(.DATA_W(DW), .NREG(32), .NRD(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .clr0     (clr0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .clr1     (clr1),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0; clr0 = 1'b0;
        we1 = 1'b0; wa1 = '0; wd1 = '0; clr1 = 1'b0;
        iss_v = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_idx[0 +: AW]  = AW'(p0);
        rd_idx[AW +: AW] = AW'(p1);
    endtask

    // Step past the next rising edge; inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd0();
        return rd_data[0 +: DW];
    endfunction

    function automatic logic [31:0] rd1();
        return rd_data[DW +: DW];
    endfunction

    initial begin
        idle();
        rstn = 1'b0;
        set_rd(5, 5);
        #2;
        chk("rst_rd0", rd0(), 32'h0);
        chk("rst_rd1", rd1(), 32'h0);
        chk("rst_busy", 32'(rd_busy), 32'h0);
        chk("rst_any", 32'(any_busy), 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Same-cycle bypass from write port 0.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
        set_rd(3, 0);
        #1;
        chk("byp_same", rd0(), 32'hDEADBEEF);
        tick();
        idle();
        set_rd(0, 3);
        #1;
        chk("byp_next", rd1(), 32'hDEADBEEF);

        // Both ports write x7; port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        set_rd(7, 3);
        #1;
        chk("coll_same", rd0(), 32'h22);
        chk("coll_other", rd1(), 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("coll_next", rd0(), 32'h22);

        // Register zero ignores writes and issue.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        iss_v = 1'b1; iss_rd = 5'd0;
        set_rd(0, 0);
        #1;
        chk("x0_same", rd0(), 32'h0);
        tick();
        idle();
        #1;
        chk("x0_next", rd1(), 32'h0);
        chk("x0_busy", 32'(rd_busy), 32'h0);
        chk("x0_any", 32'(any_busy), 32'h0);

        // Scoreboard lifecycle on x9.
        iss_v = 1'b1; iss_rd = 5'd9;
        set_rd(0, 9);
        #1;
        chk("iss_same_busy", 32'(rd_busy[1]), 32'h0);
        tick();
        idle();
        #1;
        chk("iss_next_busy", 32'(rd_busy[1]), 32'h1);
        chk("iss_next_any", 32'(any_busy), 32'h1);
        we0 = 1'b1; clr0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5A;
        #1;
        chk("clr_same_busy", 32'(rd_busy[1]), 32'h0);
        chk("clr_same_data", rd1(), 32'h5A);
        chk("clr_same_any", 32'(any_busy), 32'h1);
        tick();
        idle();
        #1;
        chk("clr_next_busy", 32'(rd_busy[1]), 32'h0);
        chk("clr_next_any", 32'(any_busy), 32'h0);
        chk("clr_next_data", rd1(), 32'h5A);

        // clr without its write enable leaves x9 pending.
        iss_v = 1'b1; iss_rd = 5'd9;
        tick();
        idle();
        clr0 = 1'b1; wa0 = 5'd9;
        #1;
        chk("clr_no_we_same", 32'(rd_busy[1]), 32'h1);
        tick();
        idle();
        #1;
        chk("clr_no_we_next", 32'(rd_busy[1]), 32'h1);

        // Issue beats a same-cycle retire of x4.
        iss_v = 1'b1; iss_rd = 5'd4;
        we1 = 1'b1; clr1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
        set_rd(4, 9);
        tick();
        idle();
        #1;
        chk("setwin_busy4", 32'(rd_busy[0]), 32'h1);
        chk("setwin_data4", rd0(), 32'h44);

        // Flush overrides a same-cycle issue of x6.
        flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd6;
        tick();
        idle();
        set_rd(4, 6);
        #1;
        chk("flush_busy", 32'(rd_busy), 32'h0);
        chk("flush_any", 32'(any_busy), 32'h0);

        // Asynchronous reset mid-run, checked without a clock edge.
        iss_v = 1'b1; iss_rd = 5'd7;
        tick();
        idle();
        set_rd(3, 7);
        #1;
        chk("pre_rst_rd0", rd0(), 32'hDEADBEEF);
        chk("pre_rst_any", 32'(any_busy), 32'h1);
        rstn = 1'b0;
        #1;
        chk("arst_rd0", rd0(), 32'h0);
        chk("arst_rd1", rd1(), 32'h0);
        chk("arst_busy", 32'(rd_busy), 32'h0);
        chk("arst_any", 32'(any_busy), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
